// File: rtl/alu_core.sv
// Pipelined 8-bit ALU; optional shift-add multiplier on opcode 14 when ALU_MUL_EN is defined.
// Latency: 2 edges from capture to out_valid; MUL takes WIDTH edges after capture.
// Backpressure: in_ready drops only while a MUL is pending; output side has none (pulse).
module alu_core #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SEL_W-1:0] selection,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
   localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(1);
   localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(2);
   localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(3);
   localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(4);
   localparam logic [SEL_W-1:0] OP_NAND = SEL_W'(5);
   localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(6);
   localparam logic [SEL_W-1:0] OP_XNOR = SEL_W'(7);
   localparam logic [SEL_W-1:0] OP_SHL  = SEL_W'(8);
   localparam logic [SEL_W-1:0] OP_SHR  = SEL_W'(9);
   localparam logic [SEL_W-1:0] OP_ROL  = SEL_W'(10);
   localparam logic [SEL_W-1:0] OP_ROR  = SEL_W'(11);
   localparam logic [SEL_W-1:0] OP_INC  = SEL_W'(12);
   localparam logic [SEL_W-1:0] OP_DEC  = SEL_W'(13);
   localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(14);
   localparam logic [SEL_W-1:0] OP_CMP  = SEL_W'(15);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [SEL_W-1:0]   sel_q;
   logic               v_q;
   logic               accept;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               mul_take;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign accept   = in_valid && in_ready;
   assign in_ready = !reset && !mul_busy;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= '0;
         v_q   <= 1'b0;
      end else begin
         v_q <= accept;
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= selection;
         end
      end
   end

   assign sum_w = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (sel_q)
         OP_ADD:  begin alu_res = sum_w[WIDTH-1:0]; alu_c = sum_w[WIDTH]; end
         OP_SUB:  begin alu_res = a_q - b_q; alu_c = (a_q < b_q); end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         OP_NAND: alu_res = ~(a_q & b_q);
         OP_NOR:  alu_res = ~(a_q | b_q);
         OP_XNOR: alu_res = ~(a_q ^ b_q);
         OP_SHL:  begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_c = a_q[WIDTH-1]; end
         OP_SHR:  begin alu_res = {1'b0, a_q[WIDTH-1:1]}; alu_c = a_q[0]; end
         OP_ROL:  begin alu_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; alu_c = a_q[WIDTH-1]; end
         OP_ROR:  begin alu_res = {a_q[0], a_q[WIDTH-1:1]}; alu_c = a_q[0]; end
         OP_INC:  begin alu_res = a_q + WIDTH'(1); alu_c = &a_q; end
         OP_DEC:  begin alu_res = a_q - WIDTH'(1); alu_c = (a_q == '0); end
         OP_MUL:  alu_res = '0;
         OP_CMP: begin
            if (a_q < b_q) begin
               alu_res = '1;
               alu_c   = 1'b1;
            end else if (a_q != b_q) begin
               alu_res = WIDTH'(1);
            end
         end
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               mul_last;
   logic [2*WIDTH-1:0] acc_next;

   assign mul_take = v_q && (sel_q == OP_MUL);
   assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_busy = (state_q == MUL) || mul_take;
   assign mul_done = mul_last;
   assign mul_prod = acc_next;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mul_take) state_d = MUL;
         MUL:     if (mul_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // The entry edge already performs iteration 0, so the counter starts at 1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (mul_take) begin
         acc_q    <= b_q[0] ? {{WIDTH{1'b0}}, a_q} : '0;
         mcand_q  <= {{(WIDTH-1){1'b0}}, a_q, 1'b0};
         mplier_q <= b_q >> 1;
         cnt_q    <= CNT_W'(1);
      end else if (state_q == MUL) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= mul_last ? '0 : cnt_q + CNT_W'(1);
      end
   end
`else
   assign mul_take = 1'b0;
   assign mul_busy = 1'b0;
   assign mul_done = 1'b0;
   assign mul_prod = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_prod[WIDTH-1:0];
            carry_out <= |mul_prod[2*WIDTH-1:WIDTH];
         end else if (v_q && !mul_take) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            carry_out <= alu_c;
         end
      end
   end

endmodule
